// File: rtl/fix_pkg.sv
// Shared types and ASCII constants for the FIX tag=value receive decoder.
package fix_pkg;

    typedef enum logic [1:0] {
        TAG   = 2'd0,
        VALUE = 2'd1,
        CKVAL = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [7:0] SOH_C  = 8'h01;
    localparam logic [7:0] EQ_C   = 8'h3d;
    localparam logic [7:0] ZERO_C = 8'h30;
    localparam logic [7:0] NINE_C = 8'h39;

    localparam int BEGIN_TAG = 8;
    localparam int CKSUM_TAG = 10;

    // Digit counters only need to reach one past the longest legal field.
    localparam int CNT_W = 4;

    function automatic logic is_dec_digit(input logic [7:0] b);
        return (b >= ZERO_C) && (b <= NINE_C);
    endfunction

endpackage

// File: rtl/fix_ascii_dec.sv
// Decimal ASCII accumulator: clear and shift-add one digit per accepted byte,
// flagging a digit that would exceed the digit-count or value limit.
module fix_ascii_dec
    import fix_pkg::*;
#(
    parameter int W           = 16,
    parameter int MAX_DIGITS  = 5,
    parameter bit CHECK_VALUE = 1'b0,
    parameter int MAX_VALUE   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic [7:0]       digit_byte,
    output logic             is_digit,
    output logic             over,
    output logic [W-1:0]     value,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     value_reg, value_next, base_value, digit_val;
    logic [CNT_W-1:0] count_reg, count_next, base_count;
    logic             value_over;

    // Clear and shift may coincide: the digit then starts a fresh number.
    assign base_value = clr ? '0 : value_reg;
    assign base_count = clr ? '0 : count_reg;
    assign digit_val  = W'(digit_byte - ZERO_C);
    assign value_next = base_value * W'(10) + digit_val;
    assign count_next = base_count + CNT_W'(1);
    assign is_digit   = is_dec_digit(digit_byte);

    generate
        if (CHECK_VALUE) begin : g_value_check
            logic [W+3:0] value_wide;
            assign value_wide = {4'd0, base_value} * (W+4)'(10) + {4'd0, digit_val};
            assign value_over = value_wide > (W+4)'(MAX_VALUE);
        end else begin : g_no_value_check
            assign value_over = 1'b0;
        end
    endgenerate

    assign over  = (count_next > CNT_W'(MAX_DIGITS)) || value_over;
    assign value = value_reg;
    assign count = count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_reg <= '0;
            count_reg <= '0;
        end else if (shift) begin
            value_reg <= value_next;
            count_reg <= count_next;
        end else if (clr) begin
            value_reg <= '0;
            count_reg <= '0;
        end
    end

endmodule

// File: rtl/fix_msg_parser.sv
// FIX receive decoder: splits the SOH-delimited byte stream into tags and value
// bytes, enforces BeginString first and verifies the trailing CheckSum field.
module fix_msg_parser
    import fix_pkg::*;
#(
    parameter int         TAG_W      = 16,
    parameter int         TAG_DIGITS = 5,
    parameter logic [7:0] SOH        = SOH_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_message_i,
    input  logic             valid_i,
    input  logic [7:0]       message_i,
    output logic             tag_valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             value_valid_o,
    output logic [7:0]       value_o,
    output logic             field_end_o,
    output logic             msg_done_o,
    output logic             msg_ok_o,
    output logic             err_o
);

    state_t           state_reg, state_next, cur_state;
    logic [7:0]       sum_reg, sum_next, snap_reg, snap_next;
    logic             first_reg, first_next;
    logic             tag_valid_reg, tag_valid_next, value_valid_reg, value_valid_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic [7:0]       value_reg, value_next;
    logic             field_end_reg, field_end_next, msg_done_reg, msg_done_next;
    logic             msg_ok_reg, msg_ok_next, err_reg, err_next, go_err;

    logic             tag_clr, tag_shift, tag_is_digit, tag_over;
    logic [TAG_W-1:0] tag_val;
    logic [CNT_W-1:0] tag_cnt;
    logic             ck_clr, ck_shift, ck_is_digit, ck_over;
    logic [7:0]       ck_val;
    logic [CNT_W-1:0] ck_cnt;

    fix_ascii_dec #(.W(TAG_W), .MAX_DIGITS(TAG_DIGITS), .CHECK_VALUE(1'b0), .MAX_VALUE(0)) u_tag_dec (
        .clk(clk), .rst(rst), .clr(tag_clr), .shift(tag_shift), .digit_byte(message_i),
        .is_digit(tag_is_digit), .over(tag_over), .value(tag_val), .count(tag_cnt)
    );

    fix_ascii_dec #(.W(8), .MAX_DIGITS(3), .CHECK_VALUE(1'b1), .MAX_VALUE(255)) u_ck_dec (
        .clk(clk), .rst(rst), .clr(ck_clr), .shift(ck_shift), .digit_byte(message_i),
        .is_digit(ck_is_digit), .over(ck_over), .value(ck_val), .count(ck_cnt)
    );

    // A start strobe overrides every state, so the same-cycle byte parses as a tag byte.
    assign cur_state = new_message_i ? TAG : state_reg;

    always_comb begin
        state_next       = new_message_i ? TAG : state_reg;
        sum_next         = new_message_i ? 8'd0 : sum_reg;
        if (valid_i) sum_next = sum_next + message_i;
        snap_next        = new_message_i ? 8'd0 : snap_reg;
        first_next       = new_message_i | first_reg;
        tag_clr          = new_message_i;
        tag_shift        = 1'b0;
        ck_clr           = new_message_i;
        ck_shift         = 1'b0;
        tag_valid_next   = 1'b0;
        tag_next         = tag_reg;
        value_valid_next = 1'b0;
        value_next       = value_reg;
        field_end_next   = 1'b0;
        msg_done_next    = 1'b0;
        msg_ok_next      = 1'b0;
        err_next         = 1'b0;
        go_err           = 1'b0;

        if (valid_i) begin
            case (cur_state)
                TAG: begin
                    if (tag_is_digit) begin
                        if (tag_over) go_err = 1'b1;
                        else          tag_shift = 1'b1;
                    end else if (message_i == EQ_C && tag_cnt != '0 && !new_message_i) begin
                        tag_valid_next = 1'b1;
                        tag_next       = tag_val;
                        tag_clr        = 1'b1;
                        first_next     = 1'b0;
                        if (first_reg && tag_val != TAG_W'(BEGIN_TAG)) begin
                            go_err = 1'b1;
                        end else if (tag_val == TAG_W'(CKSUM_TAG)) begin
                            state_next = CKVAL;
                            ck_clr     = 1'b1;
                        end else begin
                            state_next = VALUE;
                        end
                    end else begin
                        go_err = 1'b1;
                    end
                end
                VALUE: begin
                    if (message_i == SOH) begin
                        field_end_next = 1'b1;
                        snap_next      = sum_next;
                        state_next     = TAG;
                    end else begin
                        value_valid_next = 1'b1;
                        value_next       = message_i;
                    end
                end
                CKVAL: begin
                    if (ck_is_digit) begin
                        if (ck_over) go_err = 1'b1;
                        else         ck_shift = 1'b1;
                    end else if (message_i == SOH) begin
                        msg_done_next = 1'b1;
                        msg_ok_next   = (ck_cnt == CNT_W'(3)) && (ck_val == snap_reg);
                        sum_next      = 8'd0;
                        snap_next     = 8'd0;
                        first_next    = 1'b1;
                        state_next    = TAG;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (go_err) begin
            state_next = ERR;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= TAG;
            sum_reg         <= '0;
            snap_reg        <= '0;
            first_reg       <= 1'b1;
            tag_valid_reg   <= 1'b0;
            tag_reg         <= '0;
            value_valid_reg <= 1'b0;
            value_reg       <= '0;
            field_end_reg   <= 1'b0;
            msg_done_reg    <= 1'b0;
            msg_ok_reg      <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sum_reg         <= sum_next;
            snap_reg        <= snap_next;
            first_reg       <= first_next;
            tag_valid_reg   <= tag_valid_next;
            tag_reg         <= tag_next;
            value_valid_reg <= value_valid_next;
            value_reg       <= value_next;
            field_end_reg   <= field_end_next;
            msg_done_reg    <= msg_done_next;
            msg_ok_reg      <= msg_ok_next;
            err_reg         <= err_next;
        end
    end

    assign tag_valid_o   = tag_valid_reg;
    assign tag_o         = tag_reg;
    assign value_valid_o = value_valid_reg;
    assign value_o       = value_reg;
    assign field_end_o   = field_end_reg;
    assign msg_done_o    = msg_done_reg;
    assign msg_ok_o      = msg_ok_reg;
    assign err_o         = err_reg;

endmodule
